fir_host_seq: RTL and testbench

Host-side sequencer that drives the FIR core's start/done protocol from the opposite end. It accepts a stream of coefficients and samples, and writes them into the core's coefficient and sample memories. It then pulses `fir_start`, waits for `fir_done`, reads the result memory, and streams results out with valid/ready and a last flag. It sits between the system-side stream interface and the FIR core's memory and control ports, in the same clock domain as the core.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_host_rd.sv | 78 +++++++
 rtl/fir_host_seq.sv | 174 +++++++++++++++++
 tb/tb_fir_host_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and defaults for the FIR core and its host-side sequencer.
package fir_pkg;

   // Default datapath widths and the WAIT abort limit.
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_OUT_W   = 32;
   localparam int DEF_TIMEOUT = 4096;

   // Host sequencer states, in the order a run walks through them.
   typedef enum logic [2:0] {
      HS_IDLE,
      HS_LD_COEF,
      HS_LD_SMP,
      HS_KICK,
      HS_WAIT,
      HS_RD_REQ,
      HS_RD_CAP,
      HS_OUT
   } host_state_t;

   // Larger of two integers, for sizing shared counters at elaboration time.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fir_host_rd.sv
// fir_host_rd: result-read and output-register path of the host sequencer.
// Issues one result-memory read per result, captures the returned word into
// the output register and holds it until the downstream consumer takes it.
module fir_host_rd
   import fir_pkg::*;
#(
   parameter int  N_SAMPLES = 64,
   parameter int  OUT_W     = DEF_OUT_W,
   parameter int  CNT_W     = 7,
   localparam int SA_W      = $clog2(N_SAMPLES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  host_state_t       state,
   input  logic [CNT_W-1:0]  cnt,
   output logic              res_re,
   output logic [SA_W-1:0]   res_addr,
   input  logic [OUT_W-1:0]  res_rdata,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              out_fire
);

   localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(N_SAMPLES - 1);

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q,  out_data_d;
   logic             out_last_q,  out_last_d;

   // Read request, capture of the returned word, and output handshake.
   always_comb begin
      res_re      = 1'b0;
      res_addr    = '0;
      out_fire    = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      case (state)
         HS_RD_REQ: begin
            res_re   = 1'b1;
            res_addr = cnt[SA_W-1:0];
         end
         HS_RD_CAP: begin
            // Read data arrives one cycle after the request.
            out_data_d  = res_rdata;
            out_valid_d = 1'b1;
            out_last_d  = (cnt == SMP_LAST);
         end
         HS_OUT: begin
            if (out_ready) begin
               out_fire    = 1'b1;
               out_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Output register; everything returns to zero on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: rtl/fir_host_seq.sv
// fir_host_seq: host-side sequencer for the FIR core. Loads coefficients and
// samples from an input stream into the core memories, kicks the core, waits
// for completion (with an abort timer) and streams the results back out.
module fir_host_seq
   import fir_pkg::*;
#(
   parameter int  N_TAPS    = 16,
   parameter int  N_SAMPLES = 64,
   parameter int  DATA_W    = DEF_DATA_W,
   parameter int  OUT_W     = DEF_OUT_W,
   parameter int  TIMEOUT   = DEF_TIMEOUT,
   localparam int TA_W      = $clog2(N_TAPS),
   localparam int SA_W      = $clog2(N_SAMPLES),
   localparam int CNT_W     = max_int(TA_W, SA_W) + 1,
   localparam int TMR_W     = $clog2(TIMEOUT) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_go,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy,
   output logic              err_timeout,
   output logic              coef_we,
   output logic [TA_W-1:0]   coef_addr,
   output logic [DATA_W-1:0] coef_wdata,
   output logic              smp_we,
   output logic [SA_W-1:0]   smp_addr,
   output logic [DATA_W-1:0] smp_wdata,
   output logic              fir_start,
   input  logic              fir_busy,
   input  logic              fir_done,
   output logic              res_re,
   output logic [SA_W-1:0]   res_addr,
   input  logic [OUT_W-1:0]  res_rdata
);

   localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(N_TAPS - 1);
   localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(N_SAMPLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   host_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             out_fire;

   // Load, kick and wait sequencing; the read/output states only advance
   // on the handshake reported by the read path.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      in_ready    = 1'b0;
      coef_we     = 1'b0;
      coef_addr   = '0;
      coef_wdata  = '0;
      smp_we      = 1'b0;
      smp_addr    = '0;
      smp_wdata   = '0;
      fir_start   = 1'b0;
      err_timeout = 1'b0;
      case (state_q)
         HS_IDLE: begin
            if (cfg_go) begin
               state_d = HS_LD_COEF;
               cnt_d   = '0;
            end
         end
         HS_LD_COEF: begin
            in_ready = 1'b1;
            if (in_valid) begin
               coef_we    = 1'b1;
               coef_addr  = cnt_q[TA_W-1:0];
               coef_wdata = in_data;
               if (cnt_q == TAP_LAST) begin
                  state_d = HS_LD_SMP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         HS_LD_SMP: begin
            in_ready = 1'b1;
            if (in_valid) begin
               smp_we    = 1'b1;
               smp_addr  = cnt_q[SA_W-1:0];
               smp_wdata = in_data;
               if (cnt_q == SMP_LAST) begin
                  state_d = HS_KICK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         HS_KICK: begin
            // Never start a core that is still busy with a previous job.
            if (!fir_busy) begin
               fir_start = 1'b1;
               timer_d   = '0;
               state_d   = HS_WAIT;
            end
         end
         HS_WAIT: begin
            // A done arriving on the terminal timer cycle still counts.
            if (fir_done) begin
               state_d = HS_RD_REQ;
               cnt_d   = '0;
            end else if (timer_q == TMR_LAST) begin
               err_timeout = 1'b1;
               state_d     = HS_IDLE;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end
         HS_RD_REQ: state_d = HS_RD_CAP;
         HS_RD_CAP: state_d = HS_OUT;
         HS_OUT: begin
            if (out_fire) begin
               if (out_last) begin
                  state_d = HS_IDLE;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = HS_RD_REQ;
               end
            end
         end
         default: state_d = HS_IDLE;
      endcase
   end

   // Sequencer state, shared word counter and WAIT timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HS_IDLE;
         cnt_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
      end
   end

   assign busy = (state_q != HS_IDLE);

   fir_host_rd #(
      .N_SAMPLES (N_SAMPLES),
      .OUT_W     (OUT_W),
      .CNT_W     (CNT_W)
   ) u_rd (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state_q),
      .cnt       (cnt_q),
      .res_re    (res_re),
      .res_addr  (res_addr),
      .res_rdata (res_rdata),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_fire  (out_fire)
   );

endmodule

// File: tb/tb_fir_host_seq.sv
// tb_fir_host_seq: directed bench for the FIR host sequencer with a
// stream-level model of loads, kicks and result delivery.
module tb_fir_host_seq;

   localparam int NT  = 4;
   localparam int NS  = 8;
   localparam int TMO = 16;
   localparam int DW  = 16;
   localparam int OW  = 32;
   localparam int TOT = NT + NS;

   logic          clk = 1'b0;
   logic          rst_n, cfg_go, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [DW-1:0] in_data, coef_wdata, smp_wdata;
   logic [OW-1:0] out_data, res_rdata;
   logic          busy, err_timeout, coef_we, smp_we, fir_start, fir_busy, fir_done, res_re;
   logic [1:0]    coef_addr;
   logic [2:0]    smp_addr, res_addr;

   always #5 clk = ~clk;

   fir_host_seq #(.N_TAPS(NT), .N_SAMPLES(NS), .DATA_W(DW), .OUT_W(OW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_go(cfg_go), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .err_timeout(err_timeout), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_wdata(coef_wdata), .smp_we(smp_we), .smp_addr(smp_addr),
      .smp_wdata(smp_wdata), .fir_start(fir_start), .fir_busy(fir_busy), .fir_done(fir_done),
      .res_re(res_re), .res_addr(res_addr), .res_rdata(res_rdata)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int run_seq = 0, seen_seq = 0, exp_total = 0;
   int acc_n, exp_idx, start_cnt, err_cnt, first_acc, last_acc, first_caddr;
   int start_cyc, ov_cyc, err_cyc, hs_n;
   int hs_cyc [NS];
   logic [OW-1:0] rx [NS];
   logic [OW-1:0] res_mem [NS];
   logic [DW-1:0] coef_mem [NT];
   logic [DW-1:0] smp_mem [NS];
   logic [DW-1:0] words [TOT];
   logic          stall_prev, held_last, acc_b, exp_cwe, exp_swe;
   logic [OW-1:0] held_data;

   // Result memory of the model core: one-cycle read latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (res_re) res_rdata <= res_mem[res_addr];
   end

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Compare process: every cycle, check DUT outputs against the stream model.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (run_seq != seen_seq) begin
            seen_seq = run_seq;
            acc_n = 0; exp_idx = 0; start_cnt = 0; err_cnt = 0; hs_n = 0;
            first_acc = -1; last_acc = -1; first_caddr = -1;
            start_cyc = -1; ov_cyc = -1; err_cyc = -1; stall_prev = 1'b0;
         end
         // Input words: first NT accepted go to coef 0..NT-1, next NS to smp 0..NS-1.
         acc_b = in_valid && in_ready;
         if (acc_b && acc_n >= TOT) chk("extra_beat", acc_n, TOT - 1);
         exp_cwe = acc_b && (acc_n < NT);
         exp_swe = acc_b && (acc_n >= NT) && (acc_n < TOT);
         chk("coef_we", coef_we, exp_cwe);
         chk("coef_addr", coef_addr, exp_cwe ? acc_n : 0);
         chk("coef_wdata", coef_wdata, exp_cwe ? in_data : 0);
         chk("smp_we", smp_we, exp_swe);
         chk("smp_addr", smp_addr, exp_swe ? acc_n - NT : 0);
         chk("smp_wdata", smp_wdata, exp_swe ? in_data : 0);
         if (coef_we) coef_mem[coef_addr] = coef_wdata;
         if (smp_we) smp_mem[smp_addr] = smp_wdata;
         if (acc_b && acc_n < TOT) begin
            if (acc_n == 0) begin first_acc = cyc; first_caddr = coef_addr; end
            acc_n++;
            if (acc_n == TOT) last_acc = cyc;
         end
         // Core control.
         if (fir_start) begin
            start_cnt++;
            if (start_cyc < 0) start_cyc = cyc;
            chk("start_while_busy", fir_busy, 0);
         end
         if (err_timeout) begin err_cnt++; err_cyc = cyc; end
         if (err_cyc >= 0 && cyc == err_cyc + 1) chk("busy_after_timeout", busy, 0);
         // Results: in address order, held stable under backpressure.
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held_data);
            chk("hold_last", out_last, held_last);
            chk("hold_no_res_re", res_re, 0);
         end
         if (res_re) chk("res_re_while_valid", out_valid, 0);
         if (out_valid && exp_idx >= exp_total) chk("unexpected_out", out_valid, 0);
         if (out_valid && ov_cyc < 0) ov_cyc = cyc;
         if (out_valid && out_ready && exp_idx < exp_total) begin
            chk("out_data", out_data, res_mem[exp_idx]);
            chk("out_last", out_last, exp_idx == NS - 1);
            rx[exp_idx] = out_data;
            hs_cyc[hs_n] = cyc;
            hs_n++;
            exp_idx++;
         end
         stall_prev = out_valid && !out_ready;
         held_data  = out_data;
         held_last  = out_last;
      end
   end

   task automatic chk_idle_outs(input string p);
      chk({p, "_in_ready"}, in_ready, 0);
      chk({p, "_out_valid"}, out_valid, 0);
      chk({p, "_out_data"}, out_data, 0);
      chk({p, "_out_last"}, out_last, 0);
      chk({p, "_busy"}, busy, 0);
      chk({p, "_err_timeout"}, err_timeout, 0);
      chk({p, "_coef_we"}, coef_we, 0);
      chk({p, "_smp_we"}, smp_we, 0);
      chk({p, "_fir_start"}, fir_start, 0);
      chk({p, "_res_re"}, res_re, 0);
      chk({p, "_coef_addr"}, coef_addr, 0);
      chk({p, "_res_addr"}, res_addr, 0);
   endtask

   task automatic stream(input int n_words, input bit done_glitch);
      int k = 0;
      int budget = 0;
      in_valid = 1'b1;
      while (k < n_words && budget < 100) begin
         in_data  = words[k];
         fir_done = done_glitch && (k == NT + 2);
         @(negedge clk);
         if (in_ready) k++;
         @(posedge clk); #1;
         budget++;
      end
      in_valid = 1'b0;
      in_data  = '0;
      fir_done = 1'b0;
      chk("load_beats", k, n_words);
   endtask

   task automatic do_run(input int n_words, input bit busy_hold, input bit done_glitch,
                         input bit go_in_wait, input bit send_done, input bit stall);
      int budget;
      int fall_cyc = -1;
      int done_cyc;
      int st;
      exp_total = 0;
      run_seq++;
      cfg_go = 1'b1;
      @(posedge clk); #1;
      cfg_go = 1'b0;
      stream(n_words, done_glitch);
      if (n_words < TOT) return;
      if (busy_hold) begin
         repeat (10) @(posedge clk);
         #1;
         fir_busy = 1'b0;
         fall_cyc = cyc;
      end
      budget = 0;
      while (start_cnt == 0 && budget < 50) begin @(posedge clk); #1; budget++; end
      chk("start_seen", start_cnt, 1);
      if (busy_hold) chk("start_at_busy_fall", start_cyc, fall_cyc);
      else chk("start_after_load", start_cyc, last_acc + 1);
      if (!send_done) begin
         budget = 0;
         while (err_cnt == 0 && budget < 40) begin @(posedge clk); #1; budget++; end
         chk("timeout_cycle", err_cyc, start_cyc + TMO);
         repeat (3) @(posedge clk);
         #1;
         chk("timeout_pulses", err_cnt, 1);
         chk("timeout_no_out", ov_cyc, -1);
         chk("timeout_idle", busy, 0);
         return;
      end
      repeat (2) @(posedge clk);
      #1;
      if (go_in_wait) begin
         cfg_go = 1'b1;
         @(posedge clk); #1;
         cfg_go = 1'b0;
         chk("wait_go_busy", busy, 1);
         chk("wait_go_in_ready", in_ready, 0);
      end
      fir_done  = 1'b1;
      exp_total = NS;
      done_cyc  = cyc;
      @(posedge clk); #1;
      fir_done = 1'b0;
      st = 0;
      budget = 0;
      while (exp_idx < NS && budget < 200) begin
         if (stall && exp_idx == 2 && out_valid && st < 5) begin out_ready = 1'b0; st++; end
         else out_ready = 1'b1;
         @(posedge clk); #1;
         budget++;
      end
      out_ready = 1'b1;
      chk("results_received", hs_n, NS);
      chk("done_to_valid", ov_cyc, done_cyc + 3);
      chk("start_pulses", start_cnt, 1);
      if (stall) chk("stall_cycles", st, 5);
      else begin
         chk("throughput_1", hs_cyc[1] - hs_cyc[0], 3);
         chk("throughput_7", hs_cyc[7] - hs_cyc[0], 21);
      end
      @(negedge clk);
      chk("idle_after_last", busy, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish by 100000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; cfg_go = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b1; fir_busy = 1'b0; fir_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outs("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full run: coefficients 1..4, samples 10..17.
      for (int i = 0; i < NT; i++) words[i] = DW'(i + 1);
      for (int i = 0; i < NS; i++) words[NT + i] = DW'(10 + i);
      for (int i = 0; i < NS; i++) res_mem[i] = {16'(i + 1), 16'(i)};
      do_run(TOT, 0, 0, 0, 1, 0);
      chk("load_consecutive", last_acc - first_acc, TOT - 1);
      chk("coef_mem0", coef_mem[0], 1);
      chk("coef_mem3", coef_mem[3], 4);
      chk("smp_mem0", smp_mem[0], 10);
      chk("smp_mem7", smp_mem[7], 17);
      chk("rx0", rx[0], 32'h0001_0000);
      chk("rx2", rx[2], 32'h0003_0002);
      chk("rx7", rx[7], 32'h0008_0007);

      // Core busy at kick, ignored done/go, backpressure on result 3.
      words[0] = 16'h8000; words[1] = 16'h7FFF; words[2] = 16'hFFFF; words[3] = 16'h0001;
      for (int i = 0; i < NS; i++) words[NT + i] = DW'(16'h0100 + i);
      for (int i = 0; i < NS; i++) res_mem[i] = 32'hA5A5_0000 | OW'(i);
      fir_busy = 1'b1;
      do_run(TOT, 1, 1, 1, 1, 1);
      chk("coef_mem0_r2", coef_mem[0], 16'h8000);
      chk("smp_mem5_r2", smp_mem[5], 16'h0105);
      chk("rx2_r2", rx[2], 32'hA5A5_0002);
      chk("rx3_r2", rx[3], 32'hA5A5_0003);

      // Timeout: no done from the core.
      do_run(TOT, 0, 0, 0, 0, 0);

      // Reset mid-load after two coefficient beats, then a clean restart.
      for (int i = 0; i < TOT; i++) words[i] = DW'(16'h0011 + i);
      for (int i = 0; i < NS; i++) res_mem[i] = 32'h0BAD_0000 + OW'(i * 7);
      do_run(2, 0, 0, 0, 1, 0);
      rst_n = 1'b0;
      #1;
      chk_idle_outs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_run(TOT, 0, 0, 0, 1, 0);
      chk("restart_first_addr", first_caddr, 0);
      chk("restart_coef_mem0", coef_mem[0], 16'h0011);
      chk("restart_rx7", rx[7], 32'h0BAD_0031);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
